// File: rtl/freq_meter_pkg.sv
// Shared types and helpers for the gated frequency counter.
// Holds the FSM state encoding and the gate-counter width helper.
package freq_meter_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_e;

  localparam int CLK_HZ = 100_000_000;

  // Width of a counter that must reach n-1; never narrower than one bit.
  function automatic int ctr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/freq_meter_if.sv
// Control and result bundle of the frequency meter.
// master drives enable/sig_in and reads results; slave is the meter.
interface freq_meter_if #(
  parameter int COUNT_W = 28
) ();

  logic               enable;
  logic               sig_in;
  logic [COUNT_W-1:0] freq_out;
  logic               freq_valid;
  logic               overflow;
  logic               no_signal;

  modport master (
    output enable, sig_in,
    input  freq_out, freq_valid, overflow, no_signal
  );

  modport slave (
    input  enable, sig_in,
    output freq_out, freq_valid, overflow, no_signal
  );

endinterface

// File: rtl/freq_meter_sync_edge_detect.sv
// Two-flop synchronizer plus history flop for an asynchronous input.
// edge_pulse is high for one cycle after each synchronized 0->1 transition.
module sync_edge_detect (
  input  logic CLK100MHZ,
  input  logic CPU_RESETN,
  input  logic async_in,
  output logic edge_pulse
);

  logic s1_q, s2_q, s3_q;
  logic s1_d, s2_d, s3_d;

  always_comb begin
    s1_d = async_in;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign edge_pulse = s2_q & ~s3_q;

endmodule

// File: rtl/freq_meter.sv
// Gated frequency counter: counts synchronized rising edges of sig_in over
// back-to-back windows of GATE_CYCLES clocks and publishes a saturated count.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = 100_000_000,
  parameter int COUNT_W     = 28
) (
  input logic        CLK100MHZ,
  input logic        CPU_RESETN,
  freq_meter_if.slave bus
);

  localparam int                 GATE_W    = ctr_width(GATE_CYCLES);
  localparam logic [GATE_W-1:0]  GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  logic sig_edge;

  state_e             state_q, state_d;
  logic [GATE_W-1:0]  gate_ctr_q, gate_ctr_d;
  logic [COUNT_W-1:0] edge_ctr_q, edge_ctr_d;
  logic               sat_q, sat_d;
  logic [COUNT_W-1:0] freq_out_q, freq_out_d;
  logic               freq_valid_q, freq_valid_d;
  logic               overflow_q, overflow_d;
  logic               no_signal_q, no_signal_d;
  logic [COUNT_W:0]   sum;

  sync_edge_detect u_sync (
    .CLK100MHZ  (CLK100MHZ),
    .CPU_RESETN (CPU_RESETN),
    .async_in   (bus.sig_in),
    .edge_pulse (sig_edge)
  );

  // sat_q remembers edges dropped once edge_ctr pinned, so overflow reflects the true count
  assign sum = {1'b0, edge_ctr_q} + (COUNT_W + 1)'(sig_edge);

  always_comb begin
    state_d      = state_q;
    gate_ctr_d   = gate_ctr_q;
    edge_ctr_d   = edge_ctr_q;
    sat_d        = sat_q;
    freq_out_d   = freq_out_q;
    freq_valid_d = 1'b0;
    overflow_d   = overflow_q;
    no_signal_d  = no_signal_q;

    case (state_q)
      IDLE: begin
        gate_ctr_d = '0;
        edge_ctr_d = '0;
        sat_d      = 1'b0;
        if (bus.enable) begin
          state_d = MEASURE;
        end
      end

      MEASURE: begin
        if (!bus.enable) begin
          state_d    = IDLE;
          gate_ctr_d = '0;
          edge_ctr_d = '0;
          sat_d      = 1'b0;
        end else if (gate_ctr_q == GATE_LAST) begin
          freq_out_d   = (sum > {1'b0, COUNT_MAX}) ? COUNT_MAX : sum[COUNT_W-1:0];
          overflow_d   = sat_q | (sum > {1'b0, COUNT_MAX});
          no_signal_d  = (sum == '0);
          freq_valid_d = 1'b1;
          gate_ctr_d   = '0;
          edge_ctr_d   = '0;
          sat_d        = 1'b0;
        end else begin
          gate_ctr_d = gate_ctr_q + GATE_W'(1);
          if (sig_edge) begin
            if (edge_ctr_q == COUNT_MAX) begin
              sat_d = 1'b1;
            end else begin
              edge_ctr_d = edge_ctr_q + COUNT_W'(1);
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      state_q      <= IDLE;
      gate_ctr_q   <= '0;
      edge_ctr_q   <= '0;
      sat_q        <= 1'b0;
      freq_out_q   <= '0;
      freq_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      no_signal_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      gate_ctr_q   <= gate_ctr_d;
      edge_ctr_q   <= edge_ctr_d;
      sat_q        <= sat_d;
      freq_out_q   <= freq_out_d;
      freq_valid_q <= freq_valid_d;
      overflow_q   <= overflow_d;
      no_signal_q  <= no_signal_d;
    end
  end

  assign bus.freq_out   = freq_out_q;
  assign bus.freq_valid = freq_valid_q;
  assign bus.overflow   = overflow_q;
  assign bus.no_signal  = no_signal_q;

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: a wide and a 4-bit instance share stimulus; expected
// counts come from rising transitions found in the recorded per-edge samples.
module tb_freq_meter;

  localparam int G         = 100;
  localparam int MAXC      = 8192;
  localparam int SMALL_MAX = 15;
  localparam int M_LOW     = 0;
  localparam int M_HIGH    = 1;
  localparam int M_SQ      = 2;
  localparam int M_RND     = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic enable;
  logic sig;

  int   cyc = 0;
  bit   samp [MAXC];
  int   checks = 0;
  int   failures = 0;
  int   vcnt28 = 0;
  int   vcnt4 = 0;
  int   exp_pulses = 0;
  int   last_rises = 0;
  int   mode, period, phase, dens;
  int   t0, t1, t2, s, pulses_before;

  always #5 clk = ~clk;

  freq_meter_if #(.COUNT_W(28)) bus28 ();
  freq_meter_if #(.COUNT_W(4))  bus4 ();

  assign bus28.enable = enable;
  assign bus28.sig_in = sig;
  assign bus4.enable  = enable;
  assign bus4.sig_in  = sig;

  freq_meter #(.GATE_CYCLES(G), .COUNT_W(28)) dut28 (
    .CLK100MHZ  (clk),
    .CPU_RESETN (rst_n),
    .bus        (bus28)
  );

  freq_meter #(.GATE_CYCLES(G), .COUNT_W(4)) dut4 (
    .CLK100MHZ  (clk),
    .CPU_RESETN (rst_n),
    .bus        (bus4)
  );

  // Edge numbering and the sig_in value each edge sees (zero while in reset)
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (cyc < MAXC) samp[cyc] = rst_n ? sig : 1'b0;
  end

  always @(negedge clk) begin
    if (bus28.freq_valid === 1'b1) vcnt28++;
    if (bus4.freq_valid === 1'b1) vcnt4++;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input int n);
    int nxt;
    for (int i = 0; i < n; i++) begin
      nxt = cyc + 1;
      case (mode)
        M_LOW:   sig = 1'b0;
        M_HIGH:  sig = 1'b1;
        M_SQ:    sig = (((nxt - phase) % period) < (period / 2));
        default: if ($urandom_range(0, 99) < dens) sig = ~sig;
      endcase
      @(posedge clk);
      #1;
    end
  endtask

  task automatic runTo(input int target);
    if (target > cyc) applyStimulus(target - cyc);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Rises whose sample edge k lands in [start-1, start+G-2] are counted in that window
  function automatic int modelRises(input int start, input int w);
    int cnt;
    cnt = 0;
    for (int k = start + (w - 1) * G - 1; k <= start + w * G - 2; k++) begin
      if (samp[k] && !samp[k-1]) cnt++;
    end
    return cnt;
  endfunction

  task automatic checkWindow(input int start, input int w);
    int rises;
    runTo(start + w * G - 1);
    checkOutput($sformatf("valid_before_w%0d", w), 32'(bus28.freq_valid), 32'd0);
    applyStimulus(1);
    rises      = modelRises(start, w);
    last_rises = rises;
    exp_pulses++;
    checkOutput($sformatf("valid28_w%0d", w), 32'(bus28.freq_valid), 32'd1);
    checkOutput($sformatf("freq28_w%0d", w), 32'(bus28.freq_out), 32'(rises));
    checkOutput($sformatf("ovf28_w%0d", w), 32'(bus28.overflow), 32'd0);
    checkOutput($sformatf("nosig28_w%0d", w), 32'(bus28.no_signal), 32'(rises == 0));
    checkOutput($sformatf("valid4_w%0d", w), 32'(bus4.freq_valid), 32'd1);
    checkOutput($sformatf("freq4_w%0d", w), 32'(bus4.freq_out),
                32'((rises > SMALL_MAX) ? SMALL_MAX : rises));
    checkOutput($sformatf("ovf4_w%0d", w), 32'(bus4.overflow), 32'(rises > SMALL_MAX));
    checkOutput($sformatf("nosig4_w%0d", w), 32'(bus4.no_signal), 32'(rises == 0));
  endtask

  initial begin
    rst_n  = 1'b0;
    enable = 1'b0;
    sig    = 1'b0;
    mode   = M_RND;
    dens   = 50;
    period = 10;
    phase  = 0;

    applyStimulus(5);
    checkOutput("rst_freq28", 32'(bus28.freq_out), 32'd0);
    checkOutput("rst_valid28", 32'(bus28.freq_valid), 32'd0);
    checkOutput("rst_ovf28", 32'(bus28.overflow), 32'd0);
    checkOutput("rst_nosig28", 32'(bus28.no_signal), 32'd0);
    checkOutput("rst_freq4", 32'(bus4.freq_out), 32'd0);

    rst_n = 1'b1;
    applyStimulus(20);
    checkOutput("idle_no_valid", 32'(vcnt28 + vcnt4), 32'd0);

    $display("[TB] square wave, period 10");
    mode   = M_SQ;
    period = 10;
    phase  = cyc + 1;
    enable = 1'b1;
    applyStimulus(1);
    t0 = cyc;
    for (int w = 1; w <= 3; w++) checkWindow(t0, w);

    $display("[TB] constant low");
    mode = M_LOW;
    for (int w = 4; w <= 5; w++) checkWindow(t0, w);

    $display("[TB] period 2 then period 20");
    mode   = M_SQ;
    period = 2;
    phase  = cyc + 1;
    for (int w = 6; w <= 7; w++) checkWindow(t0, w);
    period = 20;
    phase  = cyc + 1;
    for (int w = 8; w <= 9; w++) checkWindow(t0, w);

    $display("[TB] random toggling");
    mode = M_RND;
    dens = $urandom_range(5, 60);
    checkWindow(t0, 10);
    dens = $urandom_range(2, 15);
    checkWindow(t0, 11);

    $display("[TB] enable dropped mid-window");
    s      = t0 + 11 * G;
    mode   = M_SQ;
    period = 10;
    phase  = cyc + 1;
    runTo(s + 49);
    enable = 1'b0;
    applyStimulus(1);
    runTo(s + 69);
    enable = 1'b1;
    applyStimulus(1);
    t1 = cyc;
    pulses_before = vcnt28;
    runTo(s + 100);
    checkOutput("idle_hold_freq28", 32'(bus28.freq_out), 32'(last_rises));
    checkOutput("partial_no_valid", 32'(bus28.freq_valid), 32'd0);
    runTo(t1 + G - 1);
    checkOutput("no_extra_pulse", 32'(vcnt28 - pulses_before), 32'd0);
    checkWindow(t1, 1);

    $display("[TB] reset mid-window with constant-high input");
    mode = M_HIGH;
    runTo(t1 + G + 59);
    rst_n = 1'b0;
    applyStimulus(1);
    checkOutput("rst2_freq28", 32'(bus28.freq_out), 32'd0);
    checkOutput("rst2_valid28", 32'(bus28.freq_valid), 32'd0);
    checkOutput("rst2_ovf4", 32'(bus4.overflow), 32'd0);
    checkOutput("rst2_nosig28", 32'(bus28.no_signal), 32'd0);
    checkOutput("rst2_freq4", 32'(bus4.freq_out), 32'd0);
    rst_n = 1'b1;
    applyStimulus(1);
    t2 = cyc;
    checkWindow(t2, 1);
    checkWindow(t2, 2);

    applyStimulus(1);
    checkOutput("pulse_total28", 32'(vcnt28), 32'(exp_pulses));
    checkOutput("pulse_total4", 32'(vcnt4), 32'(exp_pulses));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/freq_meter.md
# freq_meter

Gated frequency counter: the measuring end of the board's clock-divider outputs. It counts rising edges of an asynchronous input (typically a PMOD JA pin looped back from a divided clock, or an external source) over a fixed gate window timed from CLK100MHZ. At the end of each window it publishes the edge count, which equals frequency in Hz when the gate is 1 s. It sits beside the divider blocks and feeds LED or seven-segment display logic.

## Interface
- GATE_CYCLES, 100_000_000: gate window length in CLK100MHZ cycles (1 s); must be ≥ 2.
- COUNT_W, 28: width of the edge counter and freq_out.
- CLK100MHZ  in  1  100 MHz system clock; all logic on its rising edge.
- CPU_RESETN  in  1  reset, synchronous, active-low.
- enable  in  1  high: measure continuously; low: idle.
- sig_in  in  1  asynchronous signal under test.
- freq_out  out  COUNT_W  edges counted in the last completed window (saturating).
- freq_valid  out  1  one-cycle pulse when freq_out updates.
- overflow  out  1  last window's count saturated.
- no_signal  out  1  last window counted zero edges.

## Operation
- sig_in passes through a 2-flop synchronizer (s1 → s2), then a history flop (s3). edge = s2 & ~s3.
- States: IDLE and MEASURE.
- IDLE: gate_ctr = 0, edge_ctr = 0. Outputs hold their last values. Go to MEASURE on the edge where enable = 1.
- MEASURE, each cycle: gate_ctr increments. edge_ctr increments on edge and saturates at 2^COUNT_W−1.
- MEASURE, when gate_ctr == GATE_CYCLES−1:
  - Latch freq_out = sat(edge_ctr + edge).
  - overflow = (true sum > max).
  - no_signal = (sum == 0).
  - Pulse freq_valid.
  - Clear both counters and remain in MEASURE. Windows are back-to-back with no dead cycle, so no edge is lost or double-counted.
- enable = 0 in MEASURE: go to IDLE next edge. The partial window is discarded: no freq_valid, outputs unchanged.
- Reset (CPU_RESETN = 0 at an edge), including mid-window:
  - State = IDLE; counters = 0; synchronizer flops = 0.
  - freq_out = 0, freq_valid = 0, overflow = 0, no_signal = 0.
- Width: gate_ctr is $clog2(GATE_CYCLES) bits. Saturation compare is done at COUNT_W+1 bits.
- Maximum countable rate is 50 MHz. Inputs above that alias, and this is not flagged.

## Timing
- enable sampled high at edge t0 → MEASURE from t0. The window covers the edges t0+1 … t0+GATE_CYCLES.
- freq_out, overflow, no_signal and freq_valid are all registered and update together on edge t0+GATE_CYCLES. freq_valid is high for exactly that one cycle.
- Subsequent freq_valid pulses arrive every GATE_CYCLES cycles.
- A sig_in rise sampled at edge k is counted at edge k+2, which is 2 cycles of latency. An edge in flight at a window boundary is counted in the window in which edge is asserted.
- A constant-high sig_in after reset produces exactly one edge (the 0→1 transition) and none thereafter.

## Structure
- Package freq_meter_pkg:
  - state enum {IDLE, MEASURE}.
  - Constant CLK_HZ = 100_000_000.
  - Helper function for the counter width.
- Sub-module sync_edge_detect: CLK100MHZ, CPU_RESETN, async_in → edge_pulse (the 3-flop chain). It is reusable for buttons and switches.
- Top-level freq_meter holds the FSM, the gate and edge counters, and the output registers.

## Test plan
All scenarios use GATE_CYCLES = 100 unless stated otherwise.
- Reset held 5 cycles with sig_in toggling → freq_out = 0, freq_valid = 0, overflow = 0, no_signal = 0. freq_valid stays 0 while enable = 0.
- enable high at t0, sig_in square wave with period 10 cycles, phase-aligned to a clock edge → freq_valid at t0+100, t0+200, …; freq_out = 10 each window; no_signal = 0.
- sig_in constant low → freq_out = 0 and no_signal = 1 at every freq_valid.
- COUNT_W = 4, sig_in period 2 cycles → freq_out = 15, overflow = 1. Then switch to period 20 → next full window gives freq_out = 5, overflow = 0.
- enable dropped at t0+50 and raised at t0+70 → no freq_valid at t0+100; the next freq_valid comes exactly 100 cycles after the re-enable edge, with a count covering only the new window.
- CPU_RESETN asserted at t0+60 for 1 cycle, enable kept high → outputs return to 0. The FSM passes through IDLE, restarts, and the next freq_valid comes 100 cycles after the MEASURE entry edge.
